// File: rtl/jump_redirect_if.sv
// Redirect channel from jump_redirect to fetch.
// Handshake: the source raises redirect_valid with a stable redirect_pc and holds both
// until a rising edge where redirect_ready=1; that edge completes the transfer.
interface jump_redirect_if #(
    parameter int ADDR_W = 16
);
    logic              redirect_valid;
    logic              redirect_ready;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/jump_redirect.sv
// Turns a taken jump resolved at writeback into a PC redirect to fetch,
// then drains the pipeline for FLUSH_CYCLES while holding off new branches.
module jump_redirect #(
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          jump_inst,
    input  logic [ADDR_W-1:0]   target_in,
    input  logic [2:0]          jump_state,
    input  logic                jump,
    jump_redirect_if.master     redir,
    output logic                flush,
    output logic                jump_pred_busy,
    output logic [CNT_W-1:0]    taken_count,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t             state;
    logic [3:0]         drain_cnt;
    logic               valid_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  tgt_s1;
    logic [ADDR_W-1:0]  tgt_s2;

    assign jump_pred_busy       = (state != IDLE);
    assign fsm_state            = state;
    assign redir.redirect_valid = valid_r;
    assign redir.redirect_pc    = pc_r;

    // Target shift mirrors the jump-state stage so tgt_s2 lines up with jump_state.
    // Non-branch slots carry no meaningful target and are zeroed like squashed ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_s1 <= '0;
            tgt_s2 <= '0;
        end else begin
            tgt_s1 <= (jump_pred_busy || jump_inst == 3'd0) ? '0 : target_in;
            tgt_s2 <= tgt_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            valid_r     <= 1'b0;
            flush       <= 1'b0;
            pc_r        <= '0;
            drain_cnt   <= '0;
            taken_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (jump && jump_state != 3'd0) begin
                        pc_r    <= tgt_s2;
                        valid_r <= 1'b1;
                        flush   <= 1'b1;
                        state   <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    // No timeout: fetch may stall the redirect as long as it likes.
                    if (redir.redirect_ready) begin
                        valid_r   <= 1'b0;
                        flush     <= 1'b0;
                        drain_cnt <= DRAIN_LOAD;
                        if (taken_count != '1) begin
                            taken_count <= taken_count + CNT_W'(1);
                        end
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    flush   <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jump_redirect.sv
// Bench for jump_redirect: directed table, hand-written corner sequences and a
// randomized run against a cycle-level reference model of the redirect rules.
module tb_jump_redirect;
    localparam int ADDR_W  = 16;
    localparam int FLUSH   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [2:0]        jump_inst = 3'd0;
    logic [ADDR_W-1:0] target_in = '0;
    logic [2:0]        jump_state;
    logic              jump;
    logic              flush;
    logic              jump_pred_busy;
    logic [CNT_W-1:0]  taken_count;
    logic [1:0]        fsm_state;

    jump_redirect_if #(.ADDR_W(ADDR_W)) rif ();

    jump_redirect #(
        .ADDR_W(ADDR_W),
        .FLUSH_CYCLES(FLUSH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .jump_inst(jump_inst),
        .target_in(target_in),
        .jump_state(jump_state),
        .jump(jump),
        .redir(rif),
        .flush(flush),
        .jump_pred_busy(jump_pred_busy),
        .taken_count(taken_count),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Upstream jump-state stage: branch kind and resolved-taken flag, two stages deep.
    logic [2:0] u_k1 = 3'd0, u_k2 = 3'd0;
    logic       u_t1 = 1'b0, u_t2 = 1'b0;
    assign jump_state = u_k2;
    assign jump       = u_t2 && (u_k2 != 3'd0);

    // Reference model: an outstanding redirect, cycles of drain left, and a target delay line.
    bit                m_wait  = 1'b0;
    int                m_drain = 0;
    logic [ADDR_W-1:0] m_pc    = '0;
    int                m_cnt   = 0;
    logic [ADDR_W-1:0] m_t1    = '0, m_t2 = '0;

    int checks = 0;
    int errors = 0;

    logic              s_valid, s_flush, s_busy;
    logic [ADDR_W-1:0] s_pc;
    logic [CNT_W-1:0]  s_cnt;

    typedef struct {
        logic [2:0]        inst;
        logic [ADDR_W-1:0] tgt;
        logic              tk;
        logic              rdy;
        logic              ev;
        logic              ef;
        logic              eb;
        logic [ADDR_W-1:0] epc;
        logic [CNT_W-1:0]  ecnt;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait = 1'b0; m_drain = 0; m_pc = '0; m_cnt = 0; m_t1 = '0; m_t2 = '0;
        u_k1 = 3'd0; u_k2 = 3'd0; u_t1 = 1'b0; u_t2 = 1'b0;
    endtask

    task automatic model_step(input logic jmp, input logic [2:0] js, input logic rdy,
                              input logic [ADDR_W-1:0] tgt);
        bit busy;
        busy = m_wait || (m_drain > 0);
        if (m_wait) begin
            if (rdy) begin
                m_wait  = 1'b0;
                m_drain = FLUSH;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end else if (m_drain > 0) begin
            m_drain--;
        end else if (jmp && js != 3'd0) begin
            m_wait = 1'b1;
            m_pc   = m_t2;
        end
        m_t2 = m_t1;
        m_t1 = busy ? '0 : tgt;
    endtask

    // One clock: drive inputs, sample outputs at the falling edge, then advance models.
    task automatic cycle(input logic [2:0] inst, input logic [ADDR_W-1:0] tgt,
                         input logic tk, input logic rdy);
        logic       busy_now, jmp_now;
        logic [2:0] js_now;
        jump_inst          = inst;
        target_in          = tgt;
        rif.redirect_ready = rdy;
        @(negedge clk);
        s_valid  = rif.redirect_valid;
        s_flush  = flush;
        s_busy   = jump_pred_busy;
        s_pc     = rif.redirect_pc;
        s_cnt    = taken_count;
        busy_now = jump_pred_busy;
        jmp_now  = jump;
        js_now   = jump_state;
        chk("model_valid", 32'(s_valid), 32'(m_wait));
        chk("model_flush", 32'(s_flush), 32'(m_wait));
        chk("model_busy", 32'(s_busy), 32'(m_wait || (m_drain > 0)));
        chk("model_pc", 32'(s_pc), 32'(m_pc));
        chk("model_count", 32'(s_cnt), 32'(m_cnt));
        @(posedge clk);
        #1;
        model_step(jmp_now, js_now, rdy, tgt);
        u_k2 = u_k1;
        u_t2 = u_t1;
        u_k1 = busy_now ? 3'd0 : inst;
        u_t1 = busy_now ? 1'b0 : tk;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(3'd0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rif.redirect_ready = 1'b0;

        // Columns: inst, tgt, taken, ready | valid, flush, busy, pc, count
        tbl[0]  = '{3'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
        tbl[1]  = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
        tbl[2]  = '{3'd0, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
        tbl[3]  = '{3'd1, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
        tbl[4]  = '{3'd0, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
        tbl[5]  = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0};
        tbl[6]  = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 4'd0};
        tbl[7]  = '{3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 4'd1};
        tbl[8]  = '{3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 4'd1};
        tbl[9]  = '{3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 4'd1};
        tbl[10] = '{3'd2, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 4'd1};
        tbl[11] = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 4'd1};
        tbl[12] = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 4'd1};
        tbl[13] = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 4'd1};
        tbl[14] = '{3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 4'd1};

        // Clock/reset: outputs must be cleared while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(rif.redirect_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_busy", 32'(jump_pred_busy), 32'd0);
        chk("rst_pc", 32'(rif.redirect_pc), 32'd0);
        chk("rst_count", 32'(taken_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Idle with toggling targets, one taken B to 0x1234, then a not-taken BE.
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].inst, tbl[i].tgt, tbl[i].tk, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_flush", i), 32'(s_flush), 32'(tbl[i].ef));
            chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d_pc", i), 32'(s_pc), 32'(tbl[i].epc));
            chk($sformatf("tbl%0d_count", i), 32'(s_cnt), 32'(tbl[i].ecnt));
        end

        // Redirect stalled by fetch for five cycles.
        cycle(3'd1, 16'h00A0, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            cycle(3'd0, '0, 1'b0, 1'b0);
            chk("stall_valid", 32'(s_valid), 32'd1);
            chk("stall_flush", 32'(s_flush), 32'd1);
            chk("stall_pc", 32'(s_pc), 32'h00A0);
        end
        cycle(3'd0, '0, 1'b0, 1'b1);
        chk("stall_accept_valid", 32'(s_valid), 32'd1);
        for (int i = 0; i < 2; i++) begin
            cycle(3'd0, '0, 1'b0, 1'b0);
            chk("stall_drain_valid", 32'(s_valid), 32'd0);
            chk("stall_drain_busy", 32'(s_busy), 32'd1);
        end
        cycle(3'd0, '0, 1'b0, 1'b0);
        chk("stall_idle_busy", 32'(s_busy), 32'd0);
        chk("stall_count", 32'(s_cnt), 32'd2);

        // Two B branches back to back: only the older one redirects.
        cycle(3'd1, 16'h0100, 1'b1, 1'b0);
        cycle(3'd1, 16'h0200, 1'b1, 1'b0);
        cycle(3'd0, '0, 1'b0, 1'b0);
        cycle(3'd0, '0, 1'b0, 1'b1);
        chk("pair_valid", 32'(s_valid), 32'd1);
        chk("pair_pc", 32'(s_pc), 32'h0100);
        for (int i = 0; i < 7; i++) begin
            cycle(3'd0, '0, 1'b0, 1'b1);
            chk("pair_no_second", 32'(s_valid), 32'd0);
        end
        chk("pair_count", 32'(s_cnt), 32'd3);
        chk("pair_pc_hold", 32'(s_pc), 32'h0100);

        // Reset asserted in the middle of DRAIN.
        cycle(3'd1, 16'h0777, 1'b1, 1'b1);
        cycle(3'd0, '0, 1'b0, 1'b1);
        cycle(3'd0, '0, 1'b0, 1'b1);
        cycle(3'd0, '0, 1'b0, 1'b1);
        chk("rd_valid", 32'(s_valid), 32'd1);
        chk("rd_pc", 32'(s_pc), 32'h0777);
        #2;
        chk("rd_in_drain", 32'(jump_pred_busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("rd_busy", 32'(jump_pred_busy), 32'd0);
        chk("rd_valid_clr", 32'(rif.redirect_valid), 32'd0);
        chk("rd_pc_clr", 32'(rif.redirect_pc), 32'd0);
        chk("rd_count_clr", 32'(taken_count), 32'd0);
        chk("rd_state", 32'(fsm_state), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(3'd1, 16'h0300, 1'b1, 1'b1);
        cycle(3'd0, '0, 1'b0, 1'b1);
        cycle(3'd0, '0, 1'b0, 1'b1);
        cycle(3'd0, '0, 1'b0, 1'b1);
        chk("post_rst_valid", 32'(s_valid), 32'd1);
        chk("post_rst_pc", 32'(s_pc), 32'h0300);
        cycle(3'd0, '0, 1'b0, 1'b0);
        chk("post_rst_count", 32'(s_cnt), 32'd1);
        idle(3);

        // Randomized traffic against the reference model; counter saturates at 2^CNT_W-1.
        for (int i = 0; i < 800; i++) begin
            logic [2:0] inst;
            inst = ($urandom_range(0, 9) < 4) ? 3'($urandom_range(1, 7)) : 3'd0;
            cycle(inst, ADDR_W'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) != 0));
        end
        chk("sat_count", 32'(s_cnt), 32'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
